// File: rtl/pc_update_unit.sv
// Program-counter stage: registers the next fetch address, stalls on BUSYWAIT,
// and keeps retired-instruction and taken-redirect counters.
module pc_update_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BRANCH,
  input  logic [7:0]       OFFSET,
  input  logic             BUSYWAIT,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_PLUS4,
  output logic [WIDTH-1:0] INSTR_COUNT,
  output logic [15:0]      TAKEN_COUNT,
  output logic             RUNNING
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [15:0]      taken_q, taken_d;
  logic             running_q, running_d;
  logic             advance;
  logic [WIDTH-1:0] offset_bytes;
  logic [WIDTH-1:0] target;

  // Sign-extended word offset scaled to bytes, and the redirect target.
  always_comb begin
    offset_bytes = {{(WIDTH-10){OFFSET[7]}}, OFFSET, 2'b00};
    PC_PLUS4     = pc_q + WIDTH'(4);
    target       = PC_PLUS4 + offset_bytes;
  end

  // Next-state logic: decides when the PC advances and where the FSM goes.
  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (BUSYWAIT) state_d = STALL;
        else          advance = 1'b1;
      end
      STALL: begin
        if (!BUSYWAIT) begin
          advance = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    running_d = (state_d == RUN);
  end

  // Datapath updates applied only on an advancing edge.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    taken_d = taken_q;
    if (advance) begin
      pc_d    = BRANCH ? target : PC_PLUS4;
      instr_d = instr_q + WIDTH'(1);
      if (BRANCH && (taken_q != 16'hFFFF)) taken_d = taken_q + 16'd1;
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      taken_q   <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      taken_q   <= taken_d;
      running_q <= running_d;
    end
  end

  assign PC          = pc_q;
  assign INSTR_COUNT = instr_q;
  assign TAKEN_COUNT = taken_q;
  assign RUNNING     = running_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit: stimulus pushes hand-computed
// expectations, a monitor pops and compares one entry after every rising edge.
module tb_pc_update_unit;

  logic        CLK;
  logic        RESET;
  logic        BRANCH;
  logic [7:0]  OFFSET;
  logic        BUSYWAIT;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic [31:0] INSTR_COUNT;
  logic [15:0] TAKEN_COUNT;
  logic        RUNNING;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ic;
    logic [15:0] tc;
    logic        run;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  pc_update_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .BRANCH     (BRANCH),
    .OFFSET     (OFFSET),
    .BUSYWAIT   (BUSYWAIT),
    .PC         (PC),
    .PC_PLUS4   (PC_PLUS4),
    .INSTR_COUNT(INSTR_COUNT),
    .TAKEN_COUNT(TAKEN_COUNT),
    .RUNNING    (RUNNING)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents new state after every edge; compare against the queue.
  always @(posedge CLK) begin : monitor
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk32("pc",       PC,                 e.pc);
      chk32("pc_plus4", PC_PLUS4,           e.pc + 32'd4);
      chk32("instr",    INSTR_COUNT,        e.ic);
      chk32("taken",    {16'h0, TAKEN_COUNT}, {16'h0, e.tc});
      chk32("running",  {31'h0, RUNNING},   {31'h0, e.run});
    end
  end

  // Drive one cycle of inputs (called 2 time units after an edge) and queue
  // the state expected after the next edge.
  task automatic step(input logic rst, input logic br, input logic [7:0] off,
                      input logic busy, input logic [31:0] pc, input logic [31:0] ic,
                      input logic [15:0] tc, input logic run);
    exp_t e;
    RESET    = rst;
    BRANCH   = br;
    OFFSET   = off;
    BUSYWAIT = busy;
    e.pc = pc; e.ic = ic; e.tc = tc; e.run = run;
    q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RESET    = 1'b1;
    BRANCH   = 1'b0;
    OFFSET   = 8'h00;
    BUSYWAIT = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk32("rst_pc",      PC,                     32'h0);
    chk32("rst_instr",   INSTR_COUNT,            32'h0);
    chk32("rst_taken",   {16'h0, TAKEN_COUNT},   32'h0);
    chk32("rst_running", {31'h0, RUNNING},       32'h0);

    // BOOT edge ignores BRANCH and BUSYWAIT
    step(0, 1, 8'h05, 1, 32'h00, 0, 0, 1);
    step(0, 0, 8'h00, 0, 32'h04, 1, 0, 1);
    step(0, 0, 8'h00, 0, 32'h08, 2, 0, 1);
    step(0, 0, 8'h00, 0, 32'h0C, 3, 0, 1);
    step(0, 0, 8'h00, 0, 32'h10, 4, 0, 1);
    step(0, 0, 8'h00, 0, 32'h14, 5, 0, 1);
    step(0, 0, 8'h00, 0, 32'h18, 6, 0, 1);
    step(0, 0, 8'h00, 0, 32'h1C, 7, 0, 1);
    step(0, 0, 8'h00, 0, 32'h20, 8, 0, 1);
    // forward and backward branches
    step(0, 1, 8'h03, 0, 32'h30, 9, 1, 1);
    step(0, 1, 8'hFE, 0, 32'h2C, 10, 2, 1);
    step(0, 0, 8'h00, 0, 32'h30, 11, 2, 1);
    step(0, 0, 8'h00, 0, 32'h34, 12, 2, 1);
    step(0, 0, 8'h00, 0, 32'h38, 13, 2, 1);
    step(0, 0, 8'h00, 0, 32'h3C, 14, 2, 1);
    step(0, 0, 8'h00, 0, 32'h40, 15, 2, 1);
    // three stalled edges with BRANCH toggling, then branch on release
    step(0, 1, 8'h05, 1, 32'h40, 15, 2, 0);
    step(0, 0, 8'h05, 1, 32'h40, 15, 2, 0);
    step(0, 1, 8'h05, 1, 32'h40, 15, 2, 0);
    step(0, 1, 8'h01, 0, 32'h48, 16, 3, 1);
    // wrap-around and offset extremes
    step(0, 1, 8'hEC, 0, 32'hFFFFFFFC, 17, 4, 1);
    step(0, 0, 8'h00, 0, 32'h00000000, 18, 4, 1);
    step(0, 1, 8'h80, 0, 32'hFFFFFE04, 19, 5, 1);
    step(0, 1, 8'h7F, 0, 32'h00000004, 20, 6, 1);
    // single stalled edge costs one cycle
    step(0, 1, 8'h10, 1, 32'h04, 20, 6, 0);
    step(0, 0, 8'h00, 0, 32'h08, 21, 6, 1);
    // bring TAKEN_COUNT to 0xFFFE with self-branches (PC+4-4 keeps PC)
    for (int i = 0; i < 65528; i++)
      step(0, 1, 8'hFF, 0, 32'h08, 32'(22 + i), 16'(7 + i), 1);
    step(0, 1, 8'hFF, 0, 32'h08, 65550, 16'hFFFF, 1);
    step(0, 1, 8'hFF, 0, 32'h08, 65551, 16'hFFFF, 1);
    step(0, 1, 8'hFF, 0, 32'h08, 65552, 16'hFFFF, 1);
    step(0, 0, 8'h00, 0, 32'h0C, 65553, 16'hFFFF, 1);
    step(0, 0, 8'h00, 1, 32'h0C, 65553, 16'hFFFF, 0);

    // asynchronous reset in the middle of a stalled cycle
    #1;
    RESET = 1'b1;
    #1;
    chk32("async_pc",      PC,                   32'h0);
    chk32("async_pc4",     PC_PLUS4,             32'h4);
    chk32("async_instr",   INSTR_COUNT,          32'h0);
    chk32("async_taken",   {16'h0, TAKEN_COUNT}, 32'h0);
    chk32("async_running", {31'h0, RUNNING},     32'h0);
    step(1, 1, 8'h05, 1, 32'h00, 0, 0, 0);
    step(0, 1, 8'h05, 0, 32'h00, 0, 0, 1);
    step(0, 0, 8'h00, 0, 32'h04, 1, 0, 1);
    step(0, 1, 8'h02, 0, 32'h10, 2, 1, 1);

    @(posedge CLK);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 entries left", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
